inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/inst_pack.sv | 71 +++++++
 rtl/inst_encoder.sv | 110 +++++++++++
 tb/tb_inst_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the instruction encoder: opcodes, the
// descriptor class enum, the 32-bit word type, the latched descriptor
// payload and a signed-range helper used by the field checker.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = 10;

  typedef logic [XLEN-1:0] inst_t;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_LOAD  = 3'd1,
    FMT_I_ALU = 3'd2,
    FMT_JALR  = 3'd3,
    FMT_S     = 3'd4,
    FMT_B     = 3'd5,
    FMT_LUI   = 3'd6,
    FMT_JAL   = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    fmt_e             fmt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
  } desc_t;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned n);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer and field checker.
//   desc_i   : latched field descriptor
//   inst_c_o : packed instruction word (unused fields zero)
//   err_c_o  : illegal field combination; only computed when
//              INST_ENC_ERRCHK_EN is defined, otherwise tied low
module inst_pack
  import rv32i_pkg::*;
(
  input  desc_t desc_i,
  output inst_t inst_c_o,
  output logic  err_c_o
);

  logic is_shift;
  assign is_shift = (desc_i.funct3 == F3_SLL) || (desc_i.funct3 == F3_SR);

  // Field packing; out-of-range immediates are silently truncated.
  always_comb begin
    inst_c_o = '0;
    unique case (desc_i.fmt)
      FMT_R:     inst_c_o = {desc_i.funct7, desc_i.rs2, desc_i.rs1, desc_i.funct3,
                             desc_i.rd, OPC_R};
      FMT_LOAD:  inst_c_o = {desc_i.imm[11:0], desc_i.rs1, desc_i.funct3, desc_i.rd, OPC_LOAD};
      FMT_I_ALU: begin
        if (is_shift) begin
          inst_c_o = {desc_i.funct7, desc_i.imm[4:0], desc_i.rs1, desc_i.funct3,
                      desc_i.rd, OPC_I_ALU};
        end else begin
          inst_c_o = {desc_i.imm[11:0], desc_i.rs1, desc_i.funct3, desc_i.rd, OPC_I_ALU};
        end
      end
      FMT_JALR:  inst_c_o = {desc_i.imm[11:0], desc_i.rs1, desc_i.funct3, desc_i.rd, OPC_JALR};
      FMT_S:     inst_c_o = {desc_i.imm[11:5], desc_i.rs2, desc_i.rs1, desc_i.funct3,
                             desc_i.imm[4:0], OPC_S};
      FMT_B:     inst_c_o = {desc_i.imm[12], desc_i.imm[10:5], desc_i.rs2, desc_i.rs1,
                             desc_i.funct3, desc_i.imm[4:1], desc_i.imm[11], OPC_B};
      FMT_LUI:   inst_c_o = {desc_i.imm[31:12], desc_i.rd, OPC_LUI};
      FMT_JAL:   inst_c_o = {desc_i.imm[20], desc_i.imm[10:1], desc_i.imm[11],
                             desc_i.imm[19:12], desc_i.rd, OPC_JAL};
      default:   inst_c_o = '0;
    endcase
  end

`ifdef INST_ENC_ERRCHK_EN
  logic f7_std;
  logic alt_bad;
  assign f7_std  = (desc_i.funct7 == 7'd0) || (desc_i.funct7 == F7_ALT);
  // The alternate funct7 only exists for SUB and SRA/SRAI.
  assign alt_bad = (desc_i.funct7 == F7_ALT) && (desc_i.funct3 != 3'b000) &&
                   (desc_i.funct3 != F3_SR);

  // Range and encoding legality per class.
  always_comb begin
    err_c_o = 1'b0;
    unique case (desc_i.fmt)
      FMT_R:     err_c_o = !f7_std || alt_bad;
      FMT_LOAD,
      FMT_JALR,
      FMT_S:     err_c_o = !fits_signed(desc_i.imm, 12);
      FMT_I_ALU: err_c_o = !fits_signed(desc_i.imm, 12) || (is_shift && alt_bad);
      FMT_B:     err_c_o = !fits_signed(desc_i.imm, 13) || desc_i.imm[0];
      FMT_LUI:   err_c_o = |desc_i.imm[11:0];
      FMT_JAL:   err_c_o = !fits_signed(desc_i.imm, 21) || desc_i.imm[0];
      default:   err_c_o = 1'b0;
    endcase
  end
`else
  assign err_c_o = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with instruction-memory addressing.
// S1 latches the field descriptor, inst_pack encodes it, S2 holds the word.
//   clk, rst_n         : clock, async active-low reset
//   clr                : synchronous flush of both stages and address clear
//   in_valid/in_ready  : descriptor handshake (in_fmt, in_rd, in_rs1, in_rs2,
//                        in_funct3, in_funct7, in_imm)
//   out_valid/out_ready: word handshake (out_inst, out_addr, out_err)
// Optional field checking: define INST_ENC_ERRCHK_EN.
module inst_encoder
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [XLEN-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output inst_t             out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  logic              s1_valid_q, s1_valid_d;
  desc_t             s1_desc_q, s1_desc_d;
  logic              out_valid_q, out_valid_d;
  inst_t             out_inst_q, out_inst_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  desc_t desc_in;
  inst_t pack_inst;
  logic  pack_err;
  logic  s2_adv;
  logic  s1_adv;

  assign desc_in = '{fmt: fmt_e'(in_fmt), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  // Ready is masked by clr (flush wins) and by reset.
  assign in_ready = s1_adv & ~clr & rst_n;

  inst_pack u_pack (
    .desc_i   (s1_desc_q),
    .inst_c_o (pack_inst),
    .err_c_o  (pack_err)
  );

  // Pipeline advance, flush and address counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_desc_d   = s1_desc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_addr_d  = out_addr_q;
    if (clr) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
      out_addr_d  = '0;
    end else begin
      if (s1_adv) begin
        s1_valid_d = in_valid;
        if (in_valid) s1_desc_d = desc_in;
      end
      if (s2_adv) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          out_inst_d = pack_inst;
          out_err_d  = pack_err;
        end
      end
      if (out_valid_q && out_ready) out_addr_d = out_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_desc_q   <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_desc_q   <= s1_desc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: scoreboard of expected words pushed
// on each input handshake and popped on each output handshake.
module tb_inst_encoder;

`ifdef INST_ENC_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] exp_addr = '0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'd0;
    case (f)
      3'd0: begin
        w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1;
        w[24:20] = rs2; w[31:25] = f7;
      end
      3'd1, 3'd2, 3'd3: begin
        w[6:0] = (f == 3'd1) ? 7'h03 : (f == 3'd2) ? 7'h13 : 7'h67;
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
        if (f == 3'd2 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w[24:20] = imm[4:0]; w[31:25] = f7;
        end
      end
      3'd4: begin
        w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1;
        w[24:20] = rs2; w[31:25] = imm[11:5];
      end
      3'd5: begin
        w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3;
        w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
      end
      3'd6: begin
        w[6:0] = 7'h37; w[11:7] = rd; w[31:12] = imm[31:12];
      end
      default: begin
        w[6:0] = 7'h6F; w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11];
        w[30:21] = imm[10:1]; w[31] = imm[20];
      end
    endcase
    return w;
  endfunction

  function automatic logic model_err(input logic [2:0] f, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    int s;
    logic e;
    s = $signed(imm);
    e = 1'b0;
    case (f)
      3'd0: e = (f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
      3'd1, 3'd3, 3'd4: e = (s < -2048) || (s > 2047);
      3'd2: e = (s < -2048) || (s > 2047) || (f3 == 3'd1 && f7 == 7'h20);
      3'd5: e = (s < -4096) || (s > 4095) || imm[0];
      3'd6: e = (imm[11:0] != 12'd0);
      default: e = (s < -1048576) || (s > 1048575) || imm[0];
    endcase
    return ERRCHK ? e : 1'b0;
  endfunction

  // Scoreboard: handshakes are decided at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      sb.delete();
      exp_addr = '0;
    end else begin
      if (out_valid && out_ready) begin
        out_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word %h at addr %0d, none expected", out_inst, out_addr);
        end else begin
          mon_e = sb.pop_front();
          if (out_inst !== mon_e.inst) begin
            errors++;
            $display("FAIL sb_inst: got %h expected %h", out_inst, mon_e.inst);
          end
          checks++;
          if (out_err !== mon_e.err) begin
            errors++;
            $display("FAIL sb_err: got %b expected %b (inst %h)", out_err, mon_e.err, out_inst);
          end
          checks++;
          if (out_addr !== exp_addr) begin
            errors++;
            $display("FAIL sb_addr: got %0d expected %0d", out_addr, exp_addr);
          end
        end
        exp_addr = exp_addr + 10'd1;
      end
      if (in_valid && in_ready)
        sb.push_back('{model_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm),
                       model_err(in_fmt, in_funct3, in_funct7, in_imm)});
    end
  end

  task automatic set_desc(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic rand_desc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    r = {{20{r[11]}}, r[11:0]};
      2:       r = {{11{r[20]}}, r[20:1], 1'b0};
      default: r = $urandom;
    endcase
    set_desc(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r);
  endtask

  // Offers the current descriptor and returns just after it is accepted.
  task automatic send();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL rst_out_inst: got %h expected 0", out_inst); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL rst_out_addr: got %0d expected 0", out_addr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err: got %b expected 0", out_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_golden();
    @(posedge clk); #1;
    set_desc(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_accept: in_ready %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_lat1: out_valid %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_lat2: out_valid %b expected 1", out_valid); end
    checks++; if (out_inst !== 32'h003100B3) begin errors++; $display("FAIL add_inst: got %h expected 003100b3", out_inst); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL add_addr: got %0d expected 0", out_addr); end

    @(posedge clk); #1;
    set_desc(3'd5, 5'd0, 5'd5, 5'd6, 3'd1, 7'd0, 32'hFFFF_FFF8);
    send();
    wait_out("beq");
    checks++; if (out_inst !== 32'hFE629CE3) begin errors++; $display("FAIL bne_inst: got %h expected fe629ce3", out_inst); end

    @(posedge clk); #1;
    set_desc(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send();
    wait_out("jal");
    checks++; if (out_inst !== 32'h001000EF) begin errors++; $display("FAIL jal_inst: got %h expected 001000ef", out_inst); end
    drain("golden");
  endtask

  task automatic test_stall();
    int acc;
    bit fire;
    logic [31:0] held;
    acc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_desc();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      fire = in_ready;
      if (fire) acc++;
      @(posedge clk); #1;
      if (fire) rand_desc();
    end
    checks++; if (acc != 2) begin errors++; $display("FAIL stall_accepted: got %0d expected 2", acc); end
    held = out_inst;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_inst !== held) begin errors++; $display("FAIL stall_hold: got %h expected %h", out_inst, held); end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 4; c++) begin
      @(negedge clk);
      fire = in_ready;
      if (fire) acc++;
      @(posedge clk); #1;
      if (fire && acc < 4) rand_desc();
    end
    in_valid = 1'b0;
    checks++; if (acc != 4) begin errors++; $display("FAIL stall_total: got %0d expected 4", acc); end
    drain("stall");
  endtask

  task automatic test_back_to_back();
    int c0, oc0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL b2b_clr_addr: got %0d expected 0", out_addr); end
    c0 = cyc;
    oc0 = out_count;
    for (int i = 0; i < 1025; i++) begin
      rand_desc();
      send();
    end
    checks++; if (cyc - c0 != 1025) begin errors++; $display("FAIL b2b_bubbles: took %0d cycles expected 1025", cyc - c0); end
    drain("b2b");
    checks++; if (out_count - oc0 != 1025) begin errors++; $display("FAIL b2b_count: got %0d expected 1025", out_count - oc0); end
    checks++; if (out_addr !== 10'd1) begin errors++; $display("FAIL b2b_wrap_addr: got %0d expected 1", out_addr); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) begin
      rand_desc();
      send();
    end
    clr = 1'b1;
    rand_desc();
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL clr_addr: got %0d expected 0", out_addr); end
    set_desc(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0);
    send();
    wait_out("clr_next");
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL clr_next_addr: got %0d expected 0", out_addr); end
    checks++; if (out_inst !== 32'h407302B3) begin errors++; $display("FAIL clr_next_inst: got %h expected 407302b3", out_inst); end
    drain("clr");
  endtask

  task automatic test_errchk();
    @(posedge clk); #1;
    set_desc(3'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send();
    wait_out("addi");
    checks++; if (out_inst !== 32'h80000013) begin errors++; $display("FAIL addi_inst: got %h expected 80000013", out_inst); end
    checks++; if (out_err !== ERRCHK) begin errors++; $display("FAIL addi_err: got %b expected %b", out_err, ERRCHK); end
    drain("errchk");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_desc(3'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send();
    wait_out("rstmid");
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", out_addr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_addr !== 10'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: addr %0d valid %b expected 0 0", out_addr, out_valid);
    end
    set_desc(3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
    send();
    wait_out("rstmid_next");
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL rstmid_next_addr: got %0d expected 0", out_addr); end
    drain("rstmid");
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_desc(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    test_reset();
    test_golden();
    test_stall();
    test_back_to_back();
    test_clr();
    test_errchk();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
